// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// master = controller side (consumes IR fields and zero, drives controls).
// slave  = datapath side.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;

  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol
  );

  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle CPU sequencing controller: instruction-step FSM, opcode/funct
// decode, datapath enables and mux selects.
// Optional feature macro: MCTRL_BNE_EN adds bne (opcode 000101) via BNEEX.
module multicycle_controller (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPEEX, S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
`ifdef MCTRL_BNE_EN
    , S_BNEEX
`endif
  } state_t;

  state_t     r_state;
  state_t     w_state;
  state_t     w_next;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic [2:0] w_funct_alu;
`ifdef MCTRL_BNE_EN
  logic       w_branchn;
`endif

  // R-type funct to ALU function code; unknown functs fall back to add
  always_comb begin
    case (bus.funct)
      6'b100000: w_funct_alu = 3'b010;
      6'b100010: w_funct_alu = 3'b110;
      6'b100100: w_funct_alu = 3'b000;
      6'b100101: w_funct_alu = 3'b001;
      6'b101010: w_funct_alu = 3'b111;
      6'b000000: w_funct_alu = 3'b011;
      default:   w_funct_alu = 3'b010;
    endcase
  end

  // State register; reset parks the sequencer in FETCH
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next state and Moore outputs; during reset outputs decode as FETCH
  always_comb begin
    w_state        = reset ? S_FETCH : r_state;
    w_next         = S_FETCH;
    w_pcwrite      = 1'b0;
    w_branch       = 1'b0;
`ifdef MCTRL_BNE_EN
    w_branchn      = 1'b0;
`endif
    w_memwrite     = 1'b0;
    w_irwrite      = 1'b0;
    w_regwrite     = 1'b0;
    bus.iord       = 1'b0;
    bus.regdst     = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.alusrca    = 1'b0;
    bus.alusrcb    = 2'b00;
    bus.pcsrc      = 2'b00;
    bus.alucontrol = ALU_ADD;
    case (w_state)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        w_pcwrite   = 1'b1;
        bus.alusrcb = 2'b01;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        // speculative branch target into ALUOut
        bus.alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_RTYPEEX;
          OP_BEQ:       w_next = S_BEQEX;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JEX;
`ifdef MCTRL_BNE_EN
          OP_BNE:       w_next = S_BNEEX;
`endif
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        w_next      = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.iord = 1'b1;
        w_next   = S_MEMWB;
      end
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        w_regwrite   = 1'b1;
      end
      S_MEMWR: begin
        bus.iord   = 1'b1;
        w_memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = w_funct_alu;
        w_next         = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        bus.regdst = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQEX: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = ALU_SUB;
        bus.pcsrc      = 2'b01;
        w_branch       = 1'b1;
      end
`ifdef MCTRL_BNE_EN
      S_BNEEX: begin
        bus.alusrca    = 1'b1;
        bus.alucontrol = ALU_SUB;
        bus.pcsrc      = 2'b01;
        w_branchn      = 1'b1;
      end
`endif
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        w_next      = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
      end
      S_JEX: begin
        bus.pcsrc = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write enables are killed combinationally while reset is high
  always_comb begin
`ifdef MCTRL_BNE_EN
    bus.pcen = ~reset & (w_pcwrite | (w_branch & bus.zero) | (w_branchn & ~bus.zero));
`else
    bus.pcen = ~reset & (w_pcwrite | (w_branch & bus.zero));
`endif
    bus.memwrite = ~reset & w_memwrite;
    bus.irwrite  = ~reset & w_irwrite;
    bus.regwrite = ~reset & w_regwrite;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected
// control sequences built from the instruction semantics, random zero/IR noise.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus();
  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  // pcen modes for one cycle of an instruction
  localparam int PC_NO = 0, PC_YES = 1, PC_Z = 2, PC_NZ = 3;

  function automatic logic [13:0] ctl(input logic iord, mw, irw, rd, m2r, rw, asa,
                                      input logic [1:0] asb, pcs, input logic [2:0] alu);
    return {iord, mw, irw, rd, m2r, rw, asa, asb, pcs, alu};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      6'b000000: return 3'b011;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic bit bne_on();
`ifdef MCTRL_BNE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit legal(input logic [5:0] o);
    return (o == OP_R || o == OP_LW || o == OP_SW || o == OP_BEQ ||
            o == OP_ADDI || o == OP_J || (o == OP_BNE && bne_on()));
  endfunction

  function automatic logic [14:0] observed();
    return {bus.pcen, bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
            bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol};
  endfunction

  // Runs one instruction (up to max_steps cycles). zsel: -1 random zero, else forced.
  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int max_steps,
                           input int zsel, input string name);
    logic [13:0] q[$];
    int          m[$];
    logic [14:0] exp_v, obs;
    logic        pc;
    q.push_back(ctl(0,0,1,0,0,0,0,2'b01,2'b00,3'b010)); m.push_back(PC_YES);
    q.push_back(ctl(0,0,0,0,0,0,0,2'b11,2'b00,3'b010)); m.push_back(PC_NO);
    if (o == OP_LW || o == OP_SW) begin
      q.push_back(ctl(0,0,0,0,0,0,1,2'b10,2'b00,3'b010)); m.push_back(PC_NO);
      if (o == OP_LW) begin
        q.push_back(ctl(1,0,0,0,0,0,0,2'b00,2'b00,3'b010)); m.push_back(PC_NO);
        q.push_back(ctl(0,0,0,0,1,1,0,2'b00,2'b00,3'b010)); m.push_back(PC_NO);
      end else begin
        q.push_back(ctl(1,1,0,0,0,0,0,2'b00,2'b00,3'b010)); m.push_back(PC_NO);
      end
    end else if (o == OP_R) begin
      q.push_back(ctl(0,0,0,0,0,0,1,2'b00,2'b00,alu_of(f))); m.push_back(PC_NO);
      q.push_back(ctl(0,0,0,1,0,1,0,2'b00,2'b00,3'b010));    m.push_back(PC_NO);
    end else if (o == OP_BEQ) begin
      q.push_back(ctl(0,0,0,0,0,0,1,2'b00,2'b01,3'b110)); m.push_back(PC_Z);
    end else if (o == OP_ADDI) begin
      q.push_back(ctl(0,0,0,0,0,0,1,2'b10,2'b00,3'b010)); m.push_back(PC_NO);
      q.push_back(ctl(0,0,0,0,0,1,0,2'b00,2'b00,3'b010)); m.push_back(PC_NO);
    end else if (o == OP_J) begin
      q.push_back(ctl(0,0,0,0,0,0,0,2'b00,2'b10,3'b010)); m.push_back(PC_YES);
    end else if (o == OP_BNE && bne_on()) begin
      q.push_back(ctl(0,0,0,0,0,0,1,2'b00,2'b01,3'b110)); m.push_back(PC_NZ);
    end
    for (int i = 0; i < q.size() && i < max_steps; i++) begin
      #1;
      reset     = 1'b0;
      // IR contents are irrelevant during FETCH; feed noise there
      bus.op    = (i == 0) ? 6'($urandom) : o;
      bus.funct = (i == 0) ? 6'($urandom) : f;
      bus.zero  = (zsel < 0) ? 1'($urandom) : 1'(zsel);
      @(negedge clk);
      case (m[i])
        PC_YES:  pc = 1'b1;
        PC_Z:    pc = bus.zero;
        PC_NZ:   pc = ~bus.zero;
        default: pc = 1'b0;
      endcase
      exp_v = {pc, q[i]};
      obs   = observed();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s op=%b funct=%b step %0d zero=%b got %h want %h",
                 name, o, f, i, bus.zero, obs, exp_v);
      end
      @(posedge clk);
    end
  endtask

  // Cycles with reset high: enables off, selects at FETCH values
  task automatic reset_cycles(input int n, input string name);
    logic [14:0] exp_v, obs;
    exp_v = {1'b0, ctl(0,0,0,0,0,0,0,2'b01,2'b00,3'b010)};
    for (int i = 0; i < n; i++) begin
      #1;
      reset     = 1'b1;
      bus.op    = 6'($urandom);
      bus.funct = 6'($urandom);
      bus.zero  = 1'($urandom);
      @(negedge clk);
      obs = observed();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d got %h want %h", name, i, obs, exp_v);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    reset_cycles(2, "reset_init");
    // abort an R-type after RTYPEEX, i.e. reset lands on RTYPEWB
    run_instr(OP_R, 6'b100010, 3, -1, "rtype_pre_reset");
    reset_cycles(3, "reset_mid_instr");
    run_instr(OP_R, 6'b100000, 99, -1, "post_reset_rtype");
  endtask

  task automatic test_lw();
    run_instr(OP_LW, 6'($urandom), 99, -1, "lw");
    run_instr(OP_SW, 6'($urandom), 99, -1, "sw");
  endtask

  task automatic test_rtype_sweep();
    logic [5:0] fl[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                          6'b101010, 6'b000000, 6'b111111};
    foreach (fl[i]) run_instr(OP_R, fl[i], 99, -1, "rtype_sweep");
  endtask

  task automatic test_branch();
    run_instr(OP_BEQ,  6'($urandom), 99, 1, "beq_taken");
    run_instr(OP_BEQ,  6'($urandom), 99, 0, "beq_not_taken");
    run_instr(OP_ADDI, 6'($urandom), 99, 1, "addi_zero_high");
  endtask

  task automatic test_jump_illegal();
    run_instr(OP_J, 6'($urandom), 99, -1, "jump");
    run_instr(6'b111111, 6'($urandom), 99, -1, "illegal");
    run_instr(OP_J, 6'($urandom), 99, -1, "jump_after_illegal");
  endtask

  task automatic test_bne();
    run_instr(OP_BNE, 6'($urandom), 99, 0, "bne_zero0");
    run_instr(OP_BNE, 6'($urandom), 99, 1, "bne_zero1");
    run_instr(OP_LW,  6'($urandom), 99, -1, "after_bne");
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE};
    logic [5:0] o;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do o = 6'($urandom); while (legal(o));
      end else begin
        o = ops[$urandom_range(0, 6)];
      end
      run_instr(o, 6'($urandom), 99, -1, "random");
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.op    = '0;
    bus.funct = '0;
    bus.zero  = 1'b0;
    @(posedge clk);
    test_reset();
    test_lw();
    test_rtype_sweep();
    test_branch();
    test_jump_illegal();
    test_bne();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
